// File: rtl/song_sequencer_if.sv
// ROM bus between the song sequencer and the song ROM.
// Master drives address and bank select, slave returns the word.
interface song_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_song;
  logic [11:0]       rom_data;

  modport master (
    output rom_addr,
    output rom_song,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  rom_song,
    output rom_data
  );
endinterface

// File: rtl/song_sequencer.sv
// Song ROM walker: plays note events at the tempo tick rate.
// Define SONG_LOOP_EN to repeat the song instead of stopping at the end.
module song_sequencer #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 16,
  parameter int ADDR_W    = 8,
  parameter int GAP_TICKS = 1
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             pause,
  input  logic             song_sel,
  song_sequencer_if.master rom,
  output logic [5:0]       fullnote,
  output logic             note_strobe,
  output logic             song_done,
  output logic             beat
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);
  localparam logic [7:0] GAP_LD = 8'(GAP_TICKS);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, LOAD, PLAY, GAP, DONE
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              song_q, song_n;
  logic [5:0]        note_q, note_n;
  logic              strobe_n;
  logic [5:0]        dur_cnt, dur_n;
  logic [7:0]        gap_cnt, gap_n;
  logic [TW-1:0]     tick, tick_n;
  logic              sel_s1, sel_s2;
  logic              sel_v1, sel_v2;
  logic              chg;
  logic [5:0]        rd_dur;
  logic [5:0]        rd_code;

  assign rd_dur   = rom.rom_data[11:6];
  assign rd_code  = rom.rom_data[5:0];
  assign chg      = sel_v2 && (sel_s2 != song_q);
  assign beat     = (tick == '0) && !pause && (state != IDLE);
  assign fullnote = pause ? 6'd0 : note_q;
  assign song_done = (state == DONE);
  assign rom.rom_addr = addr;
  assign rom.rom_song = song_q;

  // Synchronise song_sel; valid bits mask the post-reset fill.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      sel_s1 <= 1'b0;
      sel_s2 <= 1'b0;
      sel_v1 <= 1'b0;
      sel_v2 <= 1'b0;
    end else begin
      sel_s1 <= song_sel;
      sel_s2 <= sel_s1;
      sel_v1 <= 1'b1;
      sel_v2 <= sel_v1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      addr        <= '0;
      song_q      <= 1'b0;
      note_q      <= '0;
      note_strobe <= 1'b0;
      dur_cnt     <= '0;
      gap_cnt     <= '0;
      tick        <= '0;
    end else begin
      state       <= state_n;
      addr        <= addr_n;
      song_q      <= song_n;
      note_q      <= note_n;
      note_strobe <= strobe_n;
      dur_cnt     <= dur_n;
      gap_cnt     <= gap_n;
      tick        <= tick_n;
    end
  end

  // Next-state: song change restarts, otherwise walk the song.
  always_comb begin
    state_n  = state;
    addr_n   = addr;
    song_n   = song_q;
    note_n   = note_q;
    strobe_n = 1'b0;
    dur_n    = dur_cnt;
    gap_n    = gap_cnt;
    tick_n   = tick;
    if (!pause)
      tick_n = (tick == '0) ? TICK_MAX : tick - TW'(1);
    if (chg) begin
      song_n  = sel_s2;
      addr_n  = '0;
      note_n  = '0;
      tick_n  = '0;
      state_n = FETCH;
    end else begin
      unique case (state)
        IDLE: begin
          song_n  = song_sel;
          state_n = FETCH;
        end
        FETCH: state_n = WAIT;
        WAIT:  state_n = LOAD;
        LOAD: begin
          if (rd_dur == 6'd0) begin
            note_n = '0;
`ifdef SONG_LOOP_EN
            addr_n  = '0;
            state_n = FETCH;
`else
            state_n = DONE;
`endif
          end else begin
            dur_n    = rd_dur;
            note_n   = rd_code;
            strobe_n = (rd_code != 6'd0);
            state_n  = PLAY;
          end
        end
        PLAY: begin
          if (beat) begin
            if (dur_cnt == 6'd1) begin
              note_n = '0;
              if (GAP_TICKS > 0) begin
                gap_n   = GAP_LD;
                state_n = GAP;
              end else begin
                addr_n  = addr + ADDR_W'(1);
                state_n = FETCH;
              end
            end else begin
              dur_n = dur_cnt - 6'd1;
            end
          end
        end
        GAP: begin
          if (beat) begin
            if (gap_cnt == 8'd1) begin
              addr_n  = addr + ADDR_W'(1);
              state_n = FETCH;
            end else begin
              gap_n = gap_cnt - 8'd1;
            end
          end
        end
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed scenarios plus random play,
// checked every cycle against a note-timeline model.
module tb_song_sequencer;
  localparam int CLK_HZ  = 16;
  localparam int TICK_HZ = 4;
  localparam int ADDR_W  = 8;
  localparam int GAP     = 1;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       pause = 1'b0;
  logic       song_sel = 1'b0;
  logic [5:0] fullnote;
  logic       note_strobe;
  logic       song_done;
  logic       beat;

  logic [11:0] mem [0:1][0:255];

  int vectors = 0;
  int miscompares = 0;

  song_sequencer_if #(.ADDR_W(ADDR_W)) rom ();

  song_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ),
    .ADDR_W(ADDR_W), .GAP_TICKS(GAP)
  ) dut (
    .clk(clk), .RESET(RESET), .pause(pause),
    .song_sel(song_sel), .rom(rom),
    .fullnote(fullnote), .note_strobe(note_strobe),
    .song_done(song_done), .beat(beat)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    rom.rom_data <= mem[rom.rom_song][rom.rom_addr];

  function automatic void check(string nm,
      logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t",
        nm, act, exp, $time);
    end
  endfunction

  // Model: a note occupies dur+GAP ticks, sounding for the first dur.
  bit started;
  int m_tick, m_addr, m_fetch, m_left;
  bit m_song, m_play, m_strobe, m_done;
  int m_note;
  bit hist[$];

  always @(posedge clk or posedge RESET) begin
    if (RESET) begin
      started = 0; m_tick = 0; m_addr = 0; m_fetch = 0;
      m_left = 0; m_song = 0; m_play = 0; m_strobe = 0;
      m_done = 0; m_note = 0;
      hist.delete();
    end else begin
      bit bev, chg;
      logic [11:0] w;
      bev = started && m_tick == 0 && !pause;
      chg = started && hist.size() >= 2 && hist[$-1] != m_song;
      m_strobe = 0;
      if (!pause) m_tick = (m_tick == 0) ? DIV - 1 : m_tick - 1;
      if (!started) begin
        started = 1; m_song = song_sel; m_fetch = 1;
      end else if (chg) begin
        m_song = hist[$-1]; m_addr = 0; m_note = 0; m_fetch = 1;
        m_play = 0; m_done = 0; m_tick = 0;
      end else if (m_fetch != 0) begin
        if (m_fetch < 3) m_fetch++;
        else begin
          m_fetch = 0;
          w = mem[m_song][m_addr];
          if (w[11:6] == 0) begin
            m_note = 0;
`ifdef SONG_LOOP_EN
            m_addr = 0; m_fetch = 1;
`else
            m_done = 1;
`endif
          end else begin
            m_note = int'(w[5:0]);
            m_strobe = (w[5:0] != 0);
            m_left = int'(w[11:6]) + GAP;
            m_play = 1;
          end
        end
      end else if (m_play && bev) begin
        m_left--;
        if (m_left == GAP) m_note = 0;
        if (m_left == 0) begin
          m_play = 0; m_addr = (m_addr + 1) % 256; m_fetch = 1;
        end
      end
      hist.push_back(song_sel);
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!RESET) begin
      check("fullnote", 32'(fullnote), pause ? 0 : m_note);
      check("note_strobe", 32'(note_strobe), 32'(m_strobe));
      check("song_done", 32'(song_done), 32'(m_done));
      check("beat", 32'(beat),
        32'(started && m_tick == 0 && !pause));
      check("rom_addr", 32'(rom.rom_addr), m_addr);
      check("rom_song", 32'(rom.rom_song), 32'(m_song));
    end
  end

  // Independent counters for hand-computed expectations.
  int lit_code = 0;
  int n_on = 0, n_on_beats = 0, n_strobe = 0, n_pbeats = 0;

  always @(negedge clk) begin
    if (!RESET) begin
      if (lit_code != 0 && fullnote == 6'(lit_code)) begin
        n_on++;
        if (beat) n_on_beats++;
      end
      if (note_strobe) n_strobe++;
      if (pause && beat) n_pbeats++;
    end
  end

  task automatic tick1();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    n_on = 0; n_on_beats = 0; n_strobe = 0; n_pbeats = 0;
  endtask

  task automatic clear_mem();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++) mem[b][a] = 12'h000;
  endtask

  task automatic do_reset();
    #1 RESET = 1'b1;
    pause = 1'b0;
    #1;
    check("rst_fullnote", 32'(fullnote), 0);
    check("rst_addr", 32'(rom.rom_addr), 0);
    check("rst_done", 32'(song_done), 0);
    check("rst_beat", 32'(beat), 0);
    repeat (3) @(negedge clk);
    #1 RESET = 1'b0;
    clr_cnt();
  endtask

  initial begin
    int k;
    // 1: one note then end marker
    clear_mem();
    mem[0][0] = {6'd2, 6'd12};
    lit_code = 12;
    do_reset();
    repeat (40) tick1();
    check("s1_strobes", n_strobe, 1);
    check("s1_note_cycles", n_on, 5);
    check("s1_note_beats", n_on_beats, 2);
    check("s1_done", 32'(song_done), 1);
    repeat (20) tick1();
    check("s1_done_holds", 32'(song_done), 1);

    // 2: pause mid-note
    clear_mem();
    mem[0][0] = {6'd3, 6'd7};
    lit_code = 7;
    do_reset();
    k = 0;
    while (k < 50 && !(beat && fullnote == 6'd7)) begin
      tick1(); k++;
    end
    check("s2_first_beat", 32'(k < 50), 1);
    tick1();
    pause = 1'b1;
    repeat (40) tick1();
    check("s2_pause_beats", n_pbeats, 0);
    pause = 1'b0;
    clr_cnt();
    repeat (30) tick1();
    check("s2_resume_beats", n_on_beats, 2);
    check("s2_no_restrobe", n_strobe, 0);

    // 3: song change during play
    clear_mem();
    for (int a = 0; a < 10; a++) mem[0][a] = {6'd1, 6'(10 + a)};
    mem[1][0] = {6'd2, 6'd33};
    lit_code = 0;
    song_sel = 1'b0;
    do_reset();
    k = 0;
    while (k < 200 && !(rom.rom_addr == 8'd5 && fullnote != 0)) begin
      tick1(); k++;
    end
    check("s3_at_addr5", 32'(k < 200), 1);
    song_sel = 1'b1;
    k = 0;
    while (k < 4 && !(rom.rom_song && rom.rom_addr == 0
                      && fullnote == 0)) begin
      tick1(); k++;
    end
    check("s3_restart", 32'(k < 4), 1);
    k = 0;
    while (k < 6 && fullnote != 6'd33) begin
      tick1(); k++;
    end
    check("s3_bank1_note", 32'(fullnote), 33);

    // 4: timed rest
    clear_mem();
    mem[0][0] = {6'd1, 6'd0};
    mem[0][1] = {6'd1, 6'd5};
    song_sel = 1'b0;
    do_reset();
    k = 0;
    while (k < 30 && rom.rom_addr != 8'd1) begin
      tick1(); k++;
    end
    check("s4_addr1", 32'(rom.rom_addr), 1);
    check("s4_no_strobe", n_strobe, 0);

    // 5: asynchronous reset mid-play
    clear_mem();
    mem[0][0] = {6'd3, 6'd7};
    mem[1][0] = {6'd3, 6'd7};
    song_sel = 1'b1;
    do_reset();
    k = 0;
    while (k < 30 && fullnote != 6'd7) begin
      tick1(); k++;
    end
    check("s5_playing", 32'(fullnote), 7);
    tick1();
    #2 RESET = 1'b1;
    #1;
    check("s5_fullnote", 32'(fullnote), 0);
    check("s5_song", 32'(rom.rom_song), 0);
    check("s5_strobe", 32'(note_strobe), 0);
    check("s5_beat", 32'(beat), 0);

`ifdef SONG_LOOP_EN
    begin
      int seq[$];
      int ex[5] = '{0, 1, 2, 0, 1};
      clear_mem();
      mem[0][0] = {6'd1, 6'd3};
      mem[0][1] = {6'd1, 6'd4};
      song_sel = 1'b0;
      do_reset();
      seq.push_back(int'(rom.rom_addr));
      repeat (60) begin
        tick1();
        if (int'(rom.rom_addr) != seq[$])
          seq.push_back(int'(rom.rom_addr));
        check("loop_done", 32'(song_done), 0);
      end
      for (int i = 0; i < 5; i++)
        check("loop_seq", i < seq.size() ? seq[i] : -1, ex[i]);
    end
`endif

    // 6: random songs, pause and song_sel activity
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++) begin
        logic [5:0] d, c;
        d = ($urandom_range(0, 9) == 0) ? 6'd0
            : 6'($urandom_range(1, 3));
        c = ($urandom_range(0, 4) == 0) ? 6'd0
            : 6'($urandom_range(1, 63));
        mem[b][a] = {d, c};
      end
    song_sel = 1'b0;
    do_reset();
    repeat (4000) begin
      tick1();
      if ($urandom_range(0, 39) == 0) pause = ~pause;
      if ($urandom_range(0, 299) == 0) song_sel = ~song_sel;
    end
    pause = 1'b0;

    // 7: full pass through a bank with no end marker (wrap)
    for (int a = 0; a < 256; a++)
      mem[1][a] = {6'd1, 6'($urandom_range(0, 63))};
    song_sel = 1'b1;
    do_reset();
    repeat (3000) tick1();

    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end
endmodule
